// File: rtl/keccak_absorb_packer.sv
// Packs 32-bit little-endian message words into 64-bit keccak lanes and applies
// SHA-3 multi-rate padding, so the upstream FSM only ever streams raw words.
module keccak_absorb_packer #(
    parameter int          RATE_LANES  = 17,
    parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [2:0]  s_bytes,
    output logic [63:0] din,
    output logic        din_valid,
    input  logic        buffer_full,
    output logic        last_block,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             CW        = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CW-1:0]  LAST_LANE = CW'(RATE_LANES - 1);

    typedef enum logic [2:0] {IDLE, ABSORB, SEND, PAD, FINISH} state_t;

    state_t         state;
    logic [63:0]    lane_reg;
    logic           half;
    logic [CW-1:0]  lane_cnt;
    logic           dom_pending;

    logic [2:0]     nbytes;
    logic [31:0]    masked;
    logic [3:0]     pos;
    logic           dom_fits;
    logic [63:0]    last_lane;
    logic [63:0]    pad_lane;
    logic [CW-1:0]  next_cnt;
    logic           accept;
    logic           xfer;

    assign din    = lane_reg;
    assign accept = s_valid && s_ready;
    assign xfer   = din_valid && !buffer_full;

    // Final-word lane: data bytes, then the domain byte if it still fits in this
    // lane; when it lands exactly on a full lane it spills into the next lane.
    always_comb begin
        nbytes = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
        masked = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < nbytes) masked[8*k +: 8] = s_data[8*k +: 8];
        end
        pos       = {1'b0, half, 2'b00} + {1'b0, nbytes};
        dom_fits  = (pos < 4'd8);
        last_lane = lane_reg;
        if (half) last_lane[63:32] = masked;
        else      last_lane[31:0]  = masked;
        for (int b = 0; b < 8; b++) begin
            if (dom_fits && pos[2:0] == 3'(b)) last_lane[8*b +: 8] = DOMAIN_BYTE;
        end
        if (dom_fits && lane_cnt == LAST_LANE) last_lane[63:56] = last_lane[63:56] | 8'h80;

        next_cnt = (lane_cnt == LAST_LANE) ? '0 : lane_cnt + CW'(1);
        pad_lane = '0;
        if (dom_pending)           pad_lane[7:0]   = DOMAIN_BYTE;
        if (next_cnt == LAST_LANE) pad_lane[63:56] = pad_lane[63:56] | 8'h80;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane_reg    <= '0;
            half        <= 1'b0;
            lane_cnt    <= '0;
            dom_pending <= 1'b0;
            s_ready     <= 1'b0;
            din_valid   <= 1'b0;
            last_block  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ABSORB;
                        busy        <= 1'b1;
                        s_ready     <= 1'b1;
                        err         <= 1'b0;
                        lane_reg    <= '0;
                        half        <= 1'b0;
                        lane_cnt    <= '0;
                        dom_pending <= 1'b0;
                    end
                end
                ABSORB: begin
                    if (accept) begin
                        if (s_last) begin
                            lane_reg    <= last_lane;
                            half        <= 1'b0;
                            s_ready     <= 1'b0;
                            din_valid   <= 1'b1;
                            dom_pending <= !dom_fits;
                            last_block  <= dom_fits && (lane_cnt == LAST_LANE);
                            err         <= err | (s_bytes > 3'd4);
                            state       <= PAD;
                        end else if (!half) begin
                            lane_reg[31:0] <= s_data;
                            half           <= 1'b1;
                        end else begin
                            lane_reg[63:32] <= s_data;
                            half            <= 1'b0;
                            s_ready         <= 1'b0;
                            din_valid       <= 1'b1;
                            state           <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        din_valid <= 1'b0;
                        lane_reg  <= '0;
                        lane_cnt  <= next_cnt;
                        s_ready   <= 1'b1;
                        state     <= ABSORB;
                    end
                end
                PAD: begin
                    if (xfer) begin
                        if (last_block) begin
                            din_valid  <= 1'b0;
                            last_block <= 1'b0;
                            lane_reg   <= '0;
                            lane_cnt   <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            lane_reg    <= pad_lane;
                            lane_cnt    <= next_cnt;
                            dom_pending <= 1'b0;
                            last_block  <= (next_cnt == LAST_LANE);
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb_packer.sv
// Directed bench for keccak_absorb_packer: a byte-level padding model fills a
// lane scoreboard that a negedge monitor drains as lanes transfer.
module tb_keccak_absorb_packer;

    localparam int         R   = 17;
    localparam logic [7:0] DOM = 8'h06;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [2:0]  s_bytes;
    logic [63:0] din;
    logic        din_valid;
    logic        buffer_full;
    logic        last_block;
    logic        busy;
    logic        done;
    logic        err;

    keccak_absorb_packer #(.RATE_LANES(R), .DOMAIN_BYTE(DOM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_bytes(s_bytes),
        .din(din), .din_valid(din_valid), .buffer_full(buffer_full),
        .last_block(last_block), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];
    logic [7:0]  msg_q[$];
    int          lanes_done = 0;
    logic        pending_done = 1'b0;
    logic        mon_en = 1'b0;
    logic        stall_en = 1'b0;
    logic        hold_full = 1'b0;
    int          stall_cnt = 0;
    logic [63:0] held_din = '0;

    task automatic check_output(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard drain: a lane transfers on the next posedge when valid and not stalled.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (pending_done) begin
                check_output("done_pulse", 65'({done, busy}), 65'(2'b10));
                pending_done = 1'b0;
            end
            if (!din_valid) check_output("last_block_qual", 65'(last_block), 65'd0);
            if (stall_en && din_valid && buffer_full) begin
                check_output("stall_din", 65'(din), 65'(held_din));
                check_output("stall_s_ready", 65'(s_ready), 65'd0);
            end
            if (din_valid && !buffer_full) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_lane", 65'(exp_q.size()), 65'd1);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    check_output($sformatf("lane%0d", lanes_done), {last_block, din}, e);
                    if (e[64]) pending_done = 1'b1;
                end
                lanes_done++;
            end
        end
    end

    initial begin
        buffer_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_full) begin
                buffer_full = 1'b1;
            end else if (stall_en && din_valid && lanes_done == 3 && stall_cnt < 5) begin
                if (stall_cnt == 0) held_din = din;
                buffer_full = 1'b1;
                stall_cnt++;
            end else begin
                buffer_full = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                             input logic also_start);
        int t;
        s_data = d; s_last = last; s_bytes = nb; s_valid = 1'b1; start = also_start;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check_output("s_ready_timeout", 65'(s_ready), 65'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_bytes = 3'd0; s_data = '0; start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_ctrl"}, 65'({din_valid, last_block, s_ready, busy, done, err}), 65'd0);
        check_output({tag, "_din"}, 65'(din), 65'd0);
    endtask

    // Streams msg_q as one message; the expected lanes come from padding the bytes.
    task automatic apply_stimulus(input int override_nb, input logic exp_err, input logic inject_start);
        logic [7:0]  pb[$];
        logic [63:0] ln;
        logic [31:0] d;
        logic [2:0]  nb;
        int len, words, nl, t;
        len = msg_q.size();
        pb = msg_q;
        pb.push_back(DOM);
        while (pb.size() % (R * 8) != 0) pb.push_back(8'h00);
        pb[pb.size() - 1] = pb[pb.size() - 1] | 8'h80;
        nl = pb.size() / 8;
        for (int l = 0; l < nl; l++) begin
            ln = '0;
            for (int b = 0; b < 8; b++) ln[8*b +: 8] = pb[8*l + b];
            exp_q.push_back({(l == nl - 1), ln});
        end
        lanes_done = 0;
        pulse_start();
        @(negedge clk);
        check_output("busy_after_start", 65'(busy), 65'd1);
        @(posedge clk); #1;
        words = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < words; w++) begin
            d = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*w + k < len) d[8*k +: 8] = msg_q[4*w + k];
            end
            nb = (len - 4*w >= 4) ? 3'd4 : 3'(len - 4*w);
            if (w == words - 1 && override_nb >= 0) nb = 3'(override_nb);
            send_word(d, (w == words - 1), nb, inject_start && (w == 5));
        end
        t = 0;
        while ((exp_q.size() != 0 || pending_done) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_output("msg_complete", 65'(exp_q.size()), 65'd0);
        check_output("lane_count", 65'(lanes_done), 65'(nl));
        @(posedge clk); #1;
        check_output("err_flag", 65'(err), 65'(exp_err));
        check_output("busy_after_done", 65'(busy), 65'd0);
    endtask

    task automatic load_abc(input logic with_d);
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        if (with_d) msg_q.push_back(8'h64);
    endtask

    task automatic load_counting(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
    endtask

    initial begin
        logic [63:0] ln;
        rst_n = 1'b0; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_bytes = '0;
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;

        $display("[TB] empty message");
        msg_q.delete();
        apply_stimulus(-1, 1'b0, 1'b0);

        $display("[TB] abc");
        load_abc(1'b0);
        apply_stimulus(-1, 1'b0, 1'b0);

        $display("[TB] 135-byte message with lane3 stalled");
        stall_en = 1'b1; stall_cnt = 0;
        load_counting(135);
        apply_stimulus(-1, 1'b0, 1'b0);
        check_output("stall_cycles", 65'(stall_cnt), 65'd5);
        stall_en = 1'b0;

        $display("[TB] 136-byte message, start while busy");
        load_counting(136);
        apply_stimulus(-1, 1'b0, 1'b1);

        $display("[TB] reset mid-message");
        lanes_done = 0;
        for (int l = 0; l < 6; l++) begin
            ln = '0;
            for (int b = 0; b < 8; b++) ln[8*b +: 8] = 8'(8*l + b);
            exp_q.push_back({1'b0, ln});
        end
        pulse_start();
        for (int w = 0; w < 13; w++) send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 1'b0, 3'd0, 1'b0);
        hold_full = 1'b1;
        send_word(32'h3737_3635, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check_output("lane6_pending", 65'(din_valid), 65'd1);
        check_output("lanes_before_reset", 65'(lanes_done), 65'd6);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        hold_full = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        $display("[TB] abc after reset");
        load_abc(1'b0);
        apply_stimulus(-1, 1'b0, 1'b0);

        $display("[TB] s_bytes=7 on last word");
        load_abc(1'b1);
        apply_stimulus(7, 1'b1, 1'b0);

        $display("[TB] err cleared by next start");
        load_abc(1'b0);
        apply_stimulus(-1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_packer.md
Name: keccak_absorb_packer

Overview:
- Upstream feeder for the keccak coprocessor.
- Accepts the message as a stream of 32-bit little-endian words read from local RAM by the accelerator FSM.
- Packs pairs of words into 64-bit lanes and applies SHA-3 multi-rate padding (domain byte, then 0x80 at the last rate byte).
- Delivers lanes over the keccak din / din_valid / buffer_full / last_block interface, so the FSM only streams raw words and never handles padding.

Parameters:
- RATE_LANES, 17, number of 64-bit lanes per rate block (17 = 1088 bits, SHA3-256).
- DOMAIN_BYTE, 8'h06, domain-separation / first pad byte (8'h1F for SHAKE).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- start  in  1  one-cycle pulse in IDLE; begins a new message; ignored when not IDLE.
- s_data  in  32  message word; byte 0 = s_data[7:0].
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- s_last  in  1  marks the final word of the message.
- s_bytes  in  3  valid bytes in the final word, 0..4, low bytes first; ignored unless s_last.
- din  out  64  lane to keccak; first word of a pair in [31:0].
- din_valid  out  1  lane valid.
- buffer_full  in  1  keccak stall; lane transferred when din_valid && !buffer_full.
- last_block  out  1  high together with the final lane of the final block.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the final lane transfers.
- err  out  1  sticky; set when s_last arrives with s_bytes > 4; cleared by start.

Behaviour:
- Reset values: all outputs 0; state IDLE; lane register, half flag, lane counter and byte position all 0.
- States: IDLE, ABSORB, SEND, PAD, FINISH.
- IDLE:
  - On start, go to ABSORB and clear the lane register, counter and err.
  - busy = 1 from the cycle after start.
- ABSORB:
  - s_ready = 1.
  - A non-last word fills the low half, then the high half.
  - After the high half fills, go to SEND (lane ready in din next cycle).
- SEND:
  - din_valid = 1; s_ready = 0.
  - din is held stable while buffer_full = 1.
  - On transfer, increment the lane counter modulo RATE_LANES and return to ABSORB.
- Last word (s_last) handling:
  - Treat s_bytes > 4 as 4 and set err.
  - Write s_bytes data bytes, then DOMAIN_BYTE at the next byte position p.
  - Go to PAD; remaining bytes of the block are zero.
  - The byte at offset RATE_LANES*8-1 of the current block is ORed with 8'h80.
  - If p is that final offset, the byte is DOMAIN_BYTE|8'h80.
- Exact block boundary:
  - If the message length is a multiple of the rate, the last word completes a block with no room for DOMAIN_BYTE.
  - That block transfers as normal data (last_block = 0).
  - A full extra block follows: lane 0 = {56'h0, DOMAIN_BYTE}, last lane = {8'h80, 56'h0}, all others 0.
- PAD:
  - Presents the remaining lanes of the final block in order, with the same handshake as SEND.
  - last_block = 1 only on lane RATE_LANES-1 of the final block, qualified by din_valid.
- FINISH:
  - Entered on transfer of that lane.
  - done pulses for 1 cycle; busy drops in the same cycle; return to IDLE.
- Empty message: s_last with s_bytes = 0 as the first word is legal and gives a pure padding block.
- Latency: from acceptance of the 2nd word of a pair to din_valid is 1 cycle; throughput is 1 lane per 3 cycles when unstalled.
- start while busy is ignored.
- Reset mid-operation:
  - Drops din_valid and last_block immediately (asynchronously).
  - Discards partial state; no partial lane is emitted after reset release.
- Lane counter width: $clog2(RATE_LANES); wraps to 0 after lane RATE_LANES-1.

Test Plan:
- Empty message (start, then s_last, s_bytes=0, RATE_LANES=17) -> 17 lanes:
  - lane0 = 64'h0000_0000_0000_0006, lanes 1..15 = 0, lane16 = 64'h8000_0000_0000_0000.
  - last_block only on lane16; done 1 cycle after.
- "abc" (s_data = 32'h0063_6261, s_last, s_bytes=3) -> lane0 = 64'h0000_0000_0663_6261, lane16 = 64'h8000_0000_0000_0000, err = 0.
- 135-byte message, data byte i = i[7:0] -> 17 lanes, none before it; lane16 = {8'h86, 56'h86_8584_8382_8180}; last_block on lane16.
- 136-byte message (34 words, last with s_bytes=4) -> block 1 data only, last_block never high; then block 2: lane0 = 64'h06, lane16 = 64'h8000_0000_0000_0000 with last_block; 34 lanes total.
- Backpressure: buffer_full held high 5 cycles while lane3 is presented -> din/din_valid stable, s_ready = 0, no word lost; lane order and values match the unstalled run.
- Reset mid-message after lane 5, then a new "abc" message -> all outputs 0 during reset; the second message matches the "abc" scenario exactly; s_bytes=7 on a later run sets err and is treated as 4.
